// File: rtl/fork_two_outputs_if.sv
// rtl/fork_two_outputs_if.sv - FIFO-side handshake bundle for the two-way sample fork
interface fork_two_outputs_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  in_rd_en;
  logic                  in_empty;
  logic [DATA_WIDTH-1:0] in_dout;
  logic                  outA_wr_en;
  logic                  outA_full;
  logic [DATA_WIDTH-1:0] outA_din;
  logic                  outB_wr_en;
  logic                  outB_full;
  logic [DATA_WIDTH-1:0] outB_din;

  // master: the fork itself; slave: the surrounding FIFOs
  modport master (
    output in_rd_en,
    input  in_empty,
    input  in_dout,
    output outA_wr_en,
    input  outA_full,
    output outA_din,
    output outB_wr_en,
    input  outB_full,
    output outB_din
  );

  modport slave (
    input  in_rd_en,
    output in_empty,
    output in_dout,
    input  outA_wr_en,
    output outA_full,
    input  outA_din,
    input  outB_wr_en,
    output outB_full,
    input  outB_din
  );
endinterface

// File: rtl/fork_two_outputs.sv
// rtl/fork_two_outputs.sv - pops one FWFT FIFO and pushes each sample once into FIFO A and FIFO B
module fork_two_outputs #(
  parameter int DATA_WIDTH  = 32,
  parameter bit B_NEGATE    = 1'b0,
  parameter int COUNT_WIDTH = 32
) (
  input  logic                   clock,
  input  logic                   reset,
  fork_two_outputs_if.master     bus,
  output logic [COUNT_WIDTH-1:0] pop_count
);

  localparam logic [DATA_WIDTH-1:0] MOST_NEG = {1'b1, {(DATA_WIDTH-1){1'b0}}};
  localparam logic [DATA_WIDTH-1:0] MOST_POS = {1'b0, {(DATA_WIDTH-1){1'b1}}};

  logic [DATA_WIDTH-1:0] reg_a;
  logic [DATA_WIDTH-1:0] reg_b;
  logic [DATA_WIDTH-1:0] b_next;
  logic                  valid_a;
  logic                  valid_b;
  logic                  free_a;
  logic                  free_b;
  logic                  pop;

  // Negating the most negative value would overflow, so it clamps to the most positive.
  always_comb begin
    b_next = bus.in_dout;
    if (B_NEGATE) begin
      if (bus.in_dout == MOST_NEG) begin
        b_next = MOST_POS;
      end else begin
        b_next = -bus.in_dout;
      end
    end
  end

  // Gating with reset keeps every strobe low for as long as reset is held.
  assign bus.outA_wr_en = reset && valid_a && !bus.outA_full;
  assign bus.outB_wr_en = reset && valid_b && !bus.outB_full;
  assign bus.outA_din   = reg_a;
  assign bus.outB_din   = reg_b;

  assign free_a       = !valid_a || bus.outA_wr_en;
  assign free_b       = !valid_b || bus.outB_wr_en;
  assign pop          = reset && !bus.in_empty && free_a && free_b;
  assign bus.in_rd_en = pop;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      reg_a     <= '0;
      reg_b     <= '0;
      valid_a   <= 1'b0;
      valid_b   <= 1'b0;
      pop_count <= '0;
    end else if (pop) begin
      reg_a     <= bus.in_dout;
      reg_b     <= b_next;
      valid_a   <= 1'b1;
      valid_b   <= 1'b1;
      pop_count <= pop_count + {{(COUNT_WIDTH-1){1'b0}}, 1'b1};
    end else begin
      if (bus.outA_wr_en) begin
        valid_a <= 1'b0;
      end
      if (bus.outB_wr_en) begin
        valid_b <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fork_two_outputs.sv
// tb/tb_fork_two_outputs.sv - self-checking bench for fork_two_outputs, plain and negating variants
module tb_fork_two_outputs;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        empty_q = 1'b1;
  logic [31:0] dout_q = 32'h0;
  logic        full_a = 1'b0;
  logic        full_b = 1'b0;
  logic [31:0] pc0;
  logic [31:0] pc1;

  always #5 clock = ~clock;

  fork_two_outputs_if #(.DATA_WIDTH(32)) bus0 ();
  fork_two_outputs_if #(.DATA_WIDTH(32)) bus1 ();

  assign bus0.in_empty  = empty_q;
  assign bus0.in_dout   = dout_q;
  assign bus0.outA_full = full_a;
  assign bus0.outB_full = full_b;
  assign bus1.in_empty  = empty_q;
  assign bus1.in_dout   = dout_q;
  assign bus1.outA_full = full_a;
  assign bus1.outB_full = full_b;

  fork_two_outputs #(.DATA_WIDTH(32), .B_NEGATE(1'b0), .COUNT_WIDTH(32)) u_dut0 (
    .clock(clock), .reset(reset), .bus(bus0), .pop_count(pc0)
  );
  fork_two_outputs #(.DATA_WIDTH(32), .B_NEGATE(1'b1), .COUNT_WIDTH(32)) u_dut1 (
    .clock(clock), .reset(reset), .bus(bus1), .pop_count(pc1)
  );

  int          checks = 0;
  int          errors = 0;
  logic [31:0] src[$];
  logic [31:0] exp_a[$];
  logic [31:0] exp_b0[$];
  logic [31:0] exp_b1[$];
  logic [31:0] model_count = 0;
  int          n_pop, n_wa, n_wb;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  function automatic logic [31:0] neg_sat(input logic [31:0] x);
    longint v;
    v = -longint'($signed(x));
    if (v > 64'sd2147483647) v = 64'sd2147483647;
    return v[31:0];
  endfunction

  // One clock cycle: drive inputs after the edge, predict and check before the next edge.
  task automatic step(input logic fa, input logic fb);
    bit wa, wb, rd;
    full_a  = fa;
    full_b  = fb;
    empty_q = (src.size() == 0);
    dout_q  = empty_q ? 32'h0 : src[0];
    #2;
    wa = (exp_a.size() != 0) && !fa;
    wb = (exp_b0.size() != 0) && !fb;
    rd = !empty_q && (exp_a.size() == 0 || wa) && (exp_b0.size() == 0 || wb);
    check("rd_en0", bus0.in_rd_en, rd);
    check("rd_en1", bus1.in_rd_en, rd);
    check("a_wr_en0", bus0.outA_wr_en, wa);
    check("a_wr_en1", bus1.outA_wr_en, wa);
    check("b_wr_en0", bus0.outB_wr_en, wb);
    check("b_wr_en1", bus1.outB_wr_en, wb);
    check("pop_count0", pc0, model_count);
    check("pop_count1", pc1, model_count);
    if (wa) begin
      check("a_din0", bus0.outA_din, exp_a[0]);
      check("a_din1", bus1.outA_din, exp_a[0]);
      void'(exp_a.pop_front());
      n_wa++;
    end
    if (wb) begin
      check("b_din0", bus0.outB_din, exp_b0[0]);
      check("b_din1", bus1.outB_din, exp_b1[0]);
      void'(exp_b0.pop_front());
      void'(exp_b1.pop_front());
      n_wb++;
    end
    if (rd) begin
      exp_a.push_back(src[0]);
      exp_b0.push_back(src[0]);
      exp_b1.push_back(neg_sat(src[0]));
      void'(src.pop_front());
      model_count++;
      n_pop++;
    end
    @(posedge clock);
    #1;
  endtask

  // mode 0: never full, 1: A/B full on alternating cycles, 2: random fulls
  task automatic drain(input int mode, output int cycles);
    cycles = 0;
    while ((src.size() != 0 || exp_a.size() != 0 || exp_b0.size() != 0) && cycles < 3000) begin
      case (mode)
        1:       step((cycles % 2) == 1, (cycles % 2) == 0);
        2:       step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        default: step(1'b0, 1'b0);
      endcase
      cycles++;
    end
    check("drain_done", cycles < 3000, 1);
  endtask

  task automatic clear_model();
    src.delete();
    exp_a.delete();
    exp_b0.delete();
    exp_b1.delete();
    model_count = 0;
    n_pop = 0;
    n_wa  = 0;
    n_wb  = 0;
  endtask

  initial begin
    int cyc, a0, b0, p0;
    clear_model();
    for (int i = 1; i <= 256; i++) src.push_back(32'(i));
    empty_q = 1'b0;
    dout_q  = 32'd1;
    @(posedge clock);
    @(posedge clock);
    #1;
    check("rst_rd_en", bus0.in_rd_en, 0);
    check("rst_a_wr_en", bus0.outA_wr_en, 0);
    check("rst_b_wr_en", bus1.outB_wr_en, 0);
    check("rst_a_din", bus0.outA_din, 0);
    check("rst_b_din", bus1.outB_din, 0);
    check("rst_pop_count", pc0, 0);
    reset = 1'b1;

    // 256-sample stream with no backpressure
    drain(0, cyc);
    check("stream_cycles", cyc, 257);
    check("stream_pop_count", pc0, 256);
    check("stream_writes", n_wa + n_wb, 512);

    // saturated negation corner values
    src.push_back(32'd5);
    src.push_back(-32'sd7);
    src.push_back(32'd0);
    src.push_back(32'h8000_0000);
    src.push_back(32'h7FFF_FFFF);
    drain(0, cyc);
    check("neg_model_min", neg_sat(32'h8000_0000), 32'h7FFF_FFFF);

    // A held full for 20 cycles mid-stream
    n_pop = 0; n_wa = 0; n_wb = 0;
    for (int i = 1; i <= 50; i++) src.push_back(32'(i));
    for (int i = 0; i < 10; i++) step(1'b0, 1'b0);
    a0 = n_wa; b0 = n_wb; p0 = n_pop;
    for (int i = 0; i < 20; i++) step(1'b1, 1'b0);
    check("stall_b_extra", n_wb - b0, 1);
    check("stall_a_writes", n_wa - a0, 0);
    check("stall_pops", n_pop - p0, 0);
    drain(0, cyc);
    check("stall_total_a", n_wa, 50);
    check("stall_total_b", n_wb, 50);

    // alternating backpressure, random data
    n_wa = 0; n_wb = 0;
    for (int i = 0; i < 100; i++) src.push_back($urandom);
    drain(1, cyc);
    check("alt_total_a", n_wa, 100);
    check("alt_total_b", n_wb, 100);

    // random backpressure
    for (int i = 0; i < 60; i++) src.push_back($urandom);
    drain(2, cyc);

    // asynchronous reset while both slots hold a sample
    for (int i = 0; i < 20; i++) src.push_back($urandom);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0);
    step(1'b1, 1'b1);
    full_a = 1'b0;
    full_b = 1'b0;
    #2;
    check("pre_reset_a_wr_en", bus0.outA_wr_en, 1);
    check("pre_reset_b_wr_en", bus1.outB_wr_en, 1);
    reset = 1'b0;
    #1;
    check("mid_rst_a_wr_en", bus0.outA_wr_en, 0);
    check("mid_rst_b_wr_en", bus1.outB_wr_en, 0);
    check("mid_rst_rd_en", bus0.in_rd_en, 0);
    check("mid_rst_pop_count", pc1, 0);
    clear_model();
    empty_q = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b1;
    for (int i = 10; i <= 19; i++) src.push_back(32'(i));
    drain(0, cyc);
    check("post_rst_a", n_wa, 10);
    check("post_rst_b", n_wb, 10);
    check("post_rst_cycles", cyc, 11);

    // input never offers data
    reset = 1'b0;
    #1;
    clear_model();
    @(posedge clock);
    #1;
    reset = 1'b1;
    for (int i = 0; i < 30; i++) step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    check("empty_pop_count", pc0, 0);
    check("empty_writes", n_wa + n_wb, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
